// File: rtl/move_decoder.sv
// -----------------------------------------------------------------------------
// move_decoder
//   Turns cell-selection requests into registered one-hot write enables for a
//   board of CELLS cells.  It tracks which cells are taken, whose turn it is
//   and how many moves have been played.  Illegal requests are answered with a
//   reject pulse and change no state.
//
// Optional feature (compile-time macro MOVE_DECODER_UNDO_EN):
//   Adds the undo / undo_ack ports and a last-move history.  With it, moves
//   can be taken back in LIFO order.
//
// Parameters
//   CELLS  number of board cells (width of en / occupied)
//   SEL_W  cell-index width, 2**SEL_W must be >= CELLS
//
// Ports
//   clock        rising-edge clock for all state
//   reset        asynchronous, active-high reset
//   sel          requested cell index
//   sel_valid    move request, sampled on the clock edge
//   clear_board  synchronous new-game request (highest priority)
//   undo         take back the last move (MOVE_DECODER_UNDO_EN only)
//   undo_ack     one-cycle pulse, undo performed (MOVE_DECODER_UNDO_EN only)
//   en           registered one-hot write-enable pulse for the accepted cell
//   mark         player owning the current en pulse (0 = X, 1 = O)
//   accept       one-cycle pulse, move accepted
//   reject       one-cycle pulse, request refused
//   occupied     registered occupancy map
//   player       side to move next
//   board_full   high while every cell is occupied
// -----------------------------------------------------------------------------
module move_decoder #(
    parameter int CELLS = 9,
    parameter int SEL_W = 4
) (
    input  logic             clock,
    input  logic             reset,
    input  logic [SEL_W-1:0] sel,
    input  logic             sel_valid,
    input  logic             clear_board,
`ifdef MOVE_DECODER_UNDO_EN
    input  logic             undo,
    output logic             undo_ack,
`endif
    output logic [CELLS-1:0] en,
    output logic             mark,
    output logic             accept,
    output logic             reject,
    output logic [CELLS-1:0] occupied,
    output logic             player,
    output logic             board_full
);

    localparam int CNT_W = $clog2(CELLS + 1);

    localparam logic [CNT_W-1:0] FULL_COUNT = CNT_W'(CELLS);
    localparam logic [CNT_W-1:0] ONE_COUNT  = CNT_W'(1'b1);
    localparam logic [CELLS-1:0] CELL_ONE   = CELLS'(1'b1);
    // One bit wider than sel so that CELLS == 2**SEL_W is still representable.
    localparam logic [SEL_W:0]   CELL_LIMIT = (SEL_W + 1)'(CELLS);

    // The index must be able to address every cell.
    generate
        if ((2 ** SEL_W) < CELLS) begin : g_bad_sel_width
            $error("move_decoder: SEL_W too narrow for CELLS");
        end
    endgenerate

    // Registered state and outputs
    logic [CELLS-1:0] en_r;
    logic             mark_r;
    logic             accept_r;
    logic             reject_r;
    logic [CELLS-1:0] occupied_r;
    logic             player_r;
    logic [CNT_W-1:0] count_r;
    logic             board_full_r;

    // Next-state values
    logic [CELLS-1:0] en_next_s;
    logic             mark_next_s;
    logic             accept_next_s;
    logic             reject_next_s;
    logic [CELLS-1:0] occupied_next_s;
    logic             player_next_s;
    logic [CNT_W-1:0] count_next_s;

    // Request decode
    logic [CELLS-1:0] sel_onehot_s;
    logic             sel_in_range_s;
    logic             sel_free_s;
    logic             legal_s;
    logic             hist_wr_s;

`ifdef MOVE_DECODER_UNDO_EN
    logic             undo_ack_r;
    logic             undo_ack_next_s;
    logic [SEL_W-1:0] hist_r [CELLS];
    logic [CNT_W-1:0] undo_idx_s;
    logic [CELLS-1:0] undo_onehot_s;
`endif

    // Decode the requested cell and decide whether the move is legal.
    // Out-of-range indices shift the one-hot past the top bit, giving zero.
    always_comb begin
        sel_onehot_s   = CELL_ONE << sel;
        sel_in_range_s = ({1'b0, sel} < CELL_LIMIT);
        sel_free_s     = ((occupied_r & sel_onehot_s) == {CELLS{1'b0}});
        legal_s        = sel_in_range_s & sel_free_s & ~board_full_r;
`ifdef MOVE_DECODER_UNDO_EN
        undo_idx_s     = count_r - ONE_COUNT;
        undo_onehot_s  = CELL_ONE << hist_r[undo_idx_s];
`endif
    end

    // Next-state selection: clear_board, then undo, then sel_valid.
    always_comb begin
        en_next_s       = {CELLS{1'b0}};
        mark_next_s     = 1'b0;
        accept_next_s   = 1'b0;
        reject_next_s   = 1'b0;
        occupied_next_s = occupied_r;
        player_next_s   = player_r;
        count_next_s    = count_r;
        hist_wr_s       = 1'b0;
`ifdef MOVE_DECODER_UNDO_EN
        undo_ack_next_s = 1'b0;
`endif
        if (clear_board) begin
            occupied_next_s = {CELLS{1'b0}};
            player_next_s   = 1'b0;
            count_next_s    = {CNT_W{1'b0}};
        end
`ifdef MOVE_DECODER_UNDO_EN
        else if (undo) begin
            if (count_r != {CNT_W{1'b0}}) begin
                occupied_next_s = occupied_r & ~undo_onehot_s;
                player_next_s   = ~player_r;
                count_next_s    = undo_idx_s;
                undo_ack_next_s = 1'b1;
            end else begin
                reject_next_s   = 1'b1;
            end
        end
`endif
        else if (sel_valid) begin
            if (legal_s) begin
                en_next_s       = sel_onehot_s;
                mark_next_s     = player_r;
                accept_next_s   = 1'b1;
                occupied_next_s = occupied_r | sel_onehot_s;
                player_next_s   = ~player_r;
                count_next_s    = count_r + ONE_COUNT;
                hist_wr_s       = 1'b1;
            end else begin
                reject_next_s   = 1'b1;
            end
        end else begin
            en_next_s = {CELLS{1'b0}};
        end
    end

    // State and output registers; board_full is registered from the next count.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            en_r         <= {CELLS{1'b0}};
            mark_r       <= 1'b0;
            accept_r     <= 1'b0;
            reject_r     <= 1'b0;
            occupied_r   <= {CELLS{1'b0}};
            player_r     <= 1'b0;
            count_r      <= {CNT_W{1'b0}};
            board_full_r <= 1'b0;
        end else begin
            en_r         <= en_next_s;
            mark_r       <= mark_next_s;
            accept_r     <= accept_next_s;
            reject_r     <= reject_next_s;
            occupied_r   <= occupied_next_s;
            player_r     <= player_next_s;
            count_r      <= count_next_s;
            board_full_r <= (count_next_s == FULL_COUNT);
        end
    end

`ifdef MOVE_DECODER_UNDO_EN
    // Undo acknowledge register and move history; entry k holds the cell of move k.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            undo_ack_r <= 1'b0;
            for (int i = 0; i < CELLS; i++) begin
                hist_r[i] <= {SEL_W{1'b0}};
            end
        end else begin
            undo_ack_r <= undo_ack_next_s;
            if (hist_wr_s) begin
                hist_r[count_r] <= sel;
            end else begin
                hist_r[count_r] <= hist_r[count_r];
            end
        end
    end

    assign undo_ack = undo_ack_r;
`endif

    assign en         = en_r;
    assign mark       = mark_r;
    assign accept     = accept_r;
    assign reject     = reject_r;
    assign occupied   = occupied_r;
    assign player     = player_r;
    assign board_full = board_full_r;

endmodule

// File: tb/tb_move_decoder.sv
// -----------------------------------------------------------------------------
// tb_move_decoder
//   Scoreboard bench for move_decoder.  The stimulus task updates a reference
//   model (the game kept as a list of played cells) and queues the expected
//   response; a monitor pops and compares after every active edge.
// -----------------------------------------------------------------------------
module tb_move_decoder;

    localparam int CELLS = 9;
    localparam int SEL_W = 4;

    logic             clock = 1'b0;
    logic             reset = 1'b0;
    logic [SEL_W-1:0] sel = '0;
    logic             sel_valid = 1'b0;
    logic             clear_board = 1'b0;
`ifdef MOVE_DECODER_UNDO_EN
    logic             undo = 1'b0;
    logic             undo_ack;
`endif
    logic [CELLS-1:0] en;
    logic             mark;
    logic             accept;
    logic             reject;
    logic [CELLS-1:0] occupied;
    logic             player;
    logic             board_full;

    move_decoder #(.CELLS(CELLS), .SEL_W(SEL_W)) dut (
        .clock       (clock),
        .reset       (reset),
        .sel         (sel),
        .sel_valid   (sel_valid),
        .clear_board (clear_board),
`ifdef MOVE_DECODER_UNDO_EN
        .undo        (undo),
        .undo_ack    (undo_ack),
`endif
        .en          (en),
        .mark        (mark),
        .accept      (accept),
        .reject      (reject),
        .occupied    (occupied),
        .player      (player),
        .board_full  (board_full)
    );

    always #5 clock = ~clock;

    typedef struct {
        logic [CELLS-1:0] en;
        logic             mark;
        logic             accept;
        logic             reject;
        logic             undo_ack;
        logic [CELLS-1:0] occupied;
        logic             player;
        logic             full;
    } exp_t;

    exp_t exp_q[$];
    int   moves[$];          // cells played so far, in order
    int   n_checks = 0;
    int   n_fail   = 0;
    bit   release_reset = 1'b0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
        n_checks++;
        if (act !== req) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", name, act, req, $time);
        end
    endtask

    function automatic logic [CELLS-1:0] occ_map();
        logic [CELLS-1:0] m = '0;
        foreach (moves[i]) m[moves[i]] = 1'b1;
        return m;
    endfunction

    function automatic bit is_played(input int c);
        foreach (moves[i]) if (moves[i] == c) return 1'b1;
        return 1'b0;
    endfunction

    // One request cycle: drive at negedge, update the model, queue the expectation.
    task automatic step(input bit clr, input bit sv, input int s, input bit ud);
        exp_t e;
        @(negedge clock);
        if (release_reset) begin
            reset = 1'b0;
            release_reset = 1'b0;
        end
        clear_board = clr;
        sel_valid   = sv;
        sel         = s[SEL_W-1:0];
`ifdef MOVE_DECODER_UNDO_EN
        undo        = ud;
`endif
        e = '{default: '0};
        if (clr) begin
            moves.delete();
        end
`ifdef MOVE_DECODER_UNDO_EN
        else if (ud) begin
            if (moves.size() > 0) begin
                void'(moves.pop_back());
                e.undo_ack = 1'b1;
            end else begin
                e.reject = 1'b1;
            end
        end
`endif
        else if (sv) begin
            if (s < CELLS && !is_played(s) && moves.size() < CELLS) begin
                e.en     = '0;
                e.en[s]  = 1'b1;
                e.mark   = moves.size() % 2;
                e.accept = 1'b1;
                moves.push_back(s);
            end else begin
                e.reject = 1'b1;
            end
        end
        e.occupied = occ_map();
        e.player   = moves.size() % 2;
        e.full     = (moves.size() == CELLS);
        exp_q.push_back(e);
    endtask

    task automatic rst_chk(input string tag);
        chk({tag, ".en"},       32'(en),         32'd0);
        chk({tag, ".mark"},     32'(mark),       32'd0);
        chk({tag, ".accept"},   32'(accept),     32'd0);
        chk({tag, ".reject"},   32'(reject),     32'd0);
        chk({tag, ".occupied"}, 32'(occupied),   32'd0);
        chk({tag, ".player"},   32'(player),     32'd0);
        chk({tag, ".full"},     32'(board_full), 32'd0);
`ifdef MOVE_DECODER_UNDO_EN
        chk({tag, ".undo_ack"}, 32'(undo_ack),   32'd0);
`endif
    endtask

    // Asynchronous reset in the middle of a cycle, with a request held during reset.
    task automatic mid_reset(input int s);
        @(posedge clock);
        #3;
        clear_board = 1'b0;
        sel_valid   = 1'b1;
        sel         = s[SEL_W-1:0];
        reset       = 1'b1;
        #1;
        rst_chk("async_reset");
        moves.delete();
        @(posedge clock);
        #2;
        rst_chk("req_during_reset");
        release_reset = 1'b1;
    endtask

    // Monitor: compare the DUT against the queued expectation after each edge.
    always begin : monitor
        exp_t m;
        @(posedge clock);
        #1;
        if (exp_q.size() > 0) begin
            m = exp_q.pop_front();
            chk("en",       32'(en),         32'(m.en));
            chk("accept",   32'(accept),     32'(m.accept));
            chk("reject",   32'(reject),     32'(m.reject));
            chk("occupied", 32'(occupied),   32'(m.occupied));
            chk("player",   32'(player),     32'(m.player));
            chk("full",     32'(board_full), 32'(m.full));
            if (m.accept) chk("mark", 32'(mark), 32'(m.mark));
`ifdef MOVE_DECODER_UNDO_EN
            chk("undo_ack", 32'(undo_ack),   32'(m.undo_ack));
`endif
        end
    end

    initial begin
        #1 reset = 1'b1;
        #1 rst_chk("reset");
        release_reset = 1'b1;

        step(0, 1, 4, 0);                 // first move after reset
        step(0, 1, 4, 0);                 // same cell again
        step(0, 1, 9, 0);                 // out of range
        step(0, 1, 15, 0);
        step(1, 0, 0, 0);                 // new game
        for (int i = 0; i < CELLS; i++) step(0, 1, i, 0);
        step(0, 1, 0, 0);                 // full board
        step(0, 1, 12, 0);
        step(1, 1, 2, 0);                 // clear wins over request
        step(0, 0, 0, 0);
        step(0, 1, 1, 0);
        step(0, 1, 7, 0);
        mid_reset(5);
        step(0, 1, 5, 0);                 // honoured on first edge after reset
`ifdef MOVE_DECODER_UNDO_EN
        step(1, 0, 0, 0);
        step(0, 1, 3, 0);
        step(0, 1, 7, 0);
        step(0, 0, 0, 1);
        step(0, 0, 0, 1);
        step(0, 0, 0, 1);
        step(0, 1, 6, 0);
        step(0, 1, 2, 1);                 // undo beats the request
`endif
        for (int n = 0; n < 500; n++) begin
            int  s;
            bit  clr;
            bit  sv;
            bit  ud;
            s   = ($urandom_range(0, 9) == 0) ? int'($urandom_range(9, 15))
                                              : int'($urandom_range(0, 8));
            clr = ($urandom_range(0, 39) == 0);
            sv  = ($urandom_range(0, 9) < 7);
            ud  = ($urandom_range(0, 7) == 0);
            step(clr, sv, s, ud);
            if ($urandom_range(0, 149) == 0) mid_reset(s);
        end
        step(0, 0, 0, 0);
        @(posedge clock);
        #2;
        chk("scoreboard_drain", 32'(exp_q.size()), 32'd0);
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

endmodule
